dcache_data_write_sched: RTL

Registered write scheduler for the L1 data-cache data array write port. It shares the single write port between the refill path (requester 0, normally higher priority) and the store/AMO path (requester 1). It yields to the array read port whenever a read is in flight and guarantees requester 1 forward progress with a bounded starvation counter. Its output is a single-entry pipeline register that feeds the data array write interface directly.

---
 rtl/dcache_data_write_sched.sv | 92 +++++++++
 1 files changed

// File: rtl/dcache_data_write_sched.sv
// rtl/dcache_data_write_sched.sv - data array write port scheduler with starvation bound
module dcache_data_write_sched #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_0_valid,
  output logic              io_in_0_ready,
  input  logic              io_in_0_bits_way_en,
  input  logic [ADDR_W-1:0] io_in_0_bits_addr,
  input  logic              io_in_0_bits_wmask,
  input  logic [DATA_W-1:0] io_in_0_bits_data,
  input  logic              io_in_1_valid,
  output logic              io_in_1_ready,
  input  logic              io_in_1_bits_way_en,
  input  logic [ADDR_W-1:0] io_in_1_bits_addr,
  input  logic              io_in_1_bits_wmask,
  input  logic [DATA_W-1:0] io_in_1_bits_data,
  input  logic              io_read_block,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic              io_out_bits_way_en,
  output logic [ADDR_W-1:0] io_out_bits_addr,
  output logic              io_out_bits_wmask,
  output logic [DATA_W-1:0] io_out_bits_data,
  output logic              io_out_chosen,
  output logic              io_starved
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       can_load;
  logic       grant_en;
  logic       fire_0;
  logic       fire_1;

  assign io_starved = (starve_cnt == LIMIT);

  // Arbitration: a ready is raised from priority and the other side's valid only,
  // so a requester never sees its own valid looped back into its ready.
  always_comb begin
    can_load      = !io_out_valid || io_out_ready;
    grant_en      = can_load && !io_read_block;
    io_in_0_ready = grant_en && !(io_starved && io_in_1_valid);
    io_in_1_ready = grant_en && (io_starved || !io_in_0_valid);
    fire_0        = io_in_0_valid && io_in_0_ready;
    fire_1        = io_in_1_valid && io_in_1_ready;
  end

  // Count refill grants taken while a store waits; saturates at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (fire_1 || !io_in_1_valid) begin
      starve_cnt <= 4'd0;
    end else if (fire_0) begin
      starve_cnt <= (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
    end
  end

  // Single-entry output slot: load on grant, clear on drain, hold under backpressure.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_out_valid       <= 1'b0;
      io_out_bits_way_en <= 1'b0;
      io_out_bits_addr   <= '0;
      io_out_bits_wmask  <= 1'b0;
      io_out_bits_data   <= '0;
      io_out_chosen      <= 1'b0;
    end else if (fire_0) begin
      io_out_valid       <= 1'b1;
      io_out_bits_way_en <= io_in_0_bits_way_en;
      io_out_bits_addr   <= io_in_0_bits_addr;
      io_out_bits_wmask  <= io_in_0_bits_wmask;
      io_out_bits_data   <= io_in_0_bits_data;
      io_out_chosen      <= 1'b0;
    end else if (fire_1) begin
      io_out_valid       <= 1'b1;
      io_out_bits_way_en <= io_in_1_bits_way_en;
      io_out_bits_addr   <= io_in_1_bits_addr;
      io_out_bits_wmask  <= io_in_1_bits_wmask;
      io_out_bits_data   <= io_in_1_bits_data;
      io_out_chosen      <= 1'b1;
    end else if (io_out_ready) begin
      io_out_valid       <= 1'b0;
    end
  end

endmodule
